// File: rtl/wb_openram_arbiter.sv
// rtl/wb_openram_arbiter.sv - N-port round-robin Wishbone slave sharing one OpenRAM RW port
// Registered RAM controls, byte-masked writes, per-port write permission and window decode.
module wb_openram_arbiter #(
  parameter int                    NUM_PORTS    = 2,
  parameter logic [31:0]           BASE_ADDR    = 32'h3000_0000,
  parameter int                    ADDR_WIDTH   = 8,
  parameter int                    READ_LATENCY = 1,
  parameter logic [NUM_PORTS-1:0]  WRITABLE     = {NUM_PORTS{1'b1}}
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_n_i,
  input  logic [NUM_PORTS-1:0]      wbs_stb_i,
  input  logic [NUM_PORTS-1:0]      wbs_cyc_i,
  input  logic [NUM_PORTS-1:0]      wbs_we_i,
  input  logic [4*NUM_PORTS-1:0]    wbs_sel_i,
  input  logic [32*NUM_PORTS-1:0]   wbs_dat_i,
  input  logic [32*NUM_PORTS-1:0]   wbs_adr_i,
  output logic [NUM_PORTS-1:0]      wbs_ack_o,
  output logic [32*NUM_PORTS-1:0]   wbs_dat_o,
  output logic                      ram_clk0,
  output logic                      ram_csb0,
  output logic                      ram_web0,
  output logic [3:0]                ram_wmask0,
  output logic [ADDR_WIDTH-1:0]     ram_addr0,
  output logic [31:0]               ram_din0,
  input  logic [31:0]               ram_dout0
);

  localparam int PW   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int TAGW = 30 - ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t                 r_state, w_next;
  logic [PW-1:0]          r_rr_ptr;
  logic                   r_is_write;
  logic                   r_live;
  logic [1:0]             r_cnt;
  logic [31:0]            r_dat;
  logic [NUM_PORTS-1:0]   r_ack;
  logic                   r_csb, r_web;
  logic [3:0]             r_wmask;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [31:0]            r_din;

  logic [NUM_PORTS-1:0]   w_req;
  logic                   w_win_valid;
  logic [PW-1:0]          w_win_idx;
  logic [31:0]            w_g_adr, w_g_dat;
  logic [3:0]             w_g_sel;
  logic                   w_g_we, w_ro, w_g_cyc;
  logic                   w_unused;

  function automatic logic [PW-1:0] f_wrap(input logic [PW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_PORTS) s = s - NUM_PORTS;
    return PW'(s);
  endfunction

  always_comb begin
    w_req = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_req[i] = wbs_stb_i[i] & wbs_cyc_i[i] &
                 (wbs_adr_i[32*i+ADDR_WIDTH+2 +: TAGW] == BASE_ADDR[31:ADDR_WIDTH+2]);
    end
  end

  // Scan starts just after the last winner, so the previous grantee has lowest priority.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      if (!w_win_valid && w_req[f_wrap(r_rr_ptr, k)]) begin
        w_win_valid = 1'b1;
        w_win_idx   = f_wrap(r_rr_ptr, k);
      end
    end
  end

  assign w_g_adr  = wbs_adr_i[32*w_win_idx +: 32];
  assign w_g_dat  = wbs_dat_i[32*w_win_idx +: 32];
  assign w_g_sel  = wbs_sel_i[4*w_win_idx +: 4];
  assign w_g_we   = wbs_we_i[w_win_idx];
  assign w_ro     = w_g_we & ~WRITABLE[w_win_idx];
  assign w_g_cyc  = wbs_cyc_i[r_rr_ptr];
  assign w_unused = ^{w_g_adr[1:0], w_g_adr[31:ADDR_WIDTH+2]};

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) r_state <= IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_next = w_ro ? ACK : ISSUE;
      ISSUE:   w_next = r_is_write ? ACK : WAIT;
      WAIT:    if (r_cnt == 2'd0) w_next = ACK;
      ACK:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // A master dropping cyc mid-access only loses its ack; the RAM side runs to completion.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      r_rr_ptr   <= PW'(NUM_PORTS - 1);
      r_is_write <= 1'b0;
      r_live     <= 1'b0;
      r_cnt      <= 2'd0;
      r_dat      <= 32'h0;
      r_ack      <= '0;
      r_csb      <= 1'b1;
      r_web      <= 1'b1;
      r_wmask    <= 4'h0;
      r_addr     <= '0;
      r_din      <= 32'h0;
    end else begin
      r_ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_win_valid) begin
            r_rr_ptr   <= w_win_idx;
            r_is_write <= w_g_we;
            r_live     <= 1'b1;
            if (w_ro) begin
              r_ack[w_win_idx] <= 1'b1;
            end else begin
              r_csb   <= 1'b0;
              r_web   <= ~w_g_we;
              r_wmask <= w_g_sel;
              r_addr  <= w_g_adr[ADDR_WIDTH+1:2];
              r_din   <= w_g_dat;
            end
          end
        end
        ISSUE: begin
          r_csb   <= 1'b1;
          r_web   <= 1'b1;
          r_wmask <= 4'h0;
          r_cnt   <= 2'(READ_LATENCY - 1);
          if (r_is_write) r_ack[r_rr_ptr] <= r_live & w_g_cyc;
          else if (!w_g_cyc) r_live <= 1'b0;
        end
        WAIT: begin
          if (!w_g_cyc) r_live <= 1'b0;
          if (r_cnt == 2'd0) begin
            r_dat            <= ram_dout0;
            r_ack[r_rr_ptr]  <= r_live & w_g_cyc;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign ram_clk0   = wb_clk_i;
  assign ram_csb0   = r_csb;
  assign ram_web0   = r_web;
  assign ram_wmask0 = r_wmask;
  assign ram_addr0  = r_addr;
  assign ram_din0   = r_din;
  assign wbs_ack_o  = r_ack;
  assign wbs_dat_o  = {NUM_PORTS{r_dat}};

endmodule

// File: tb/tb_wb_openram_arbiter.sv
// tb/tb_wb_openram_arbiter.sv - directed and random bench for wb_openram_arbiter
// Behavioural RAM with pipelined read latency plus a word-level expected-memory model.
module tb_wb_openram_arbiter;

  localparam int              NP   = 3;
  localparam int              AW   = 8;
  localparam int              RL   = 3;
  localparam logic [31:0]     BASE = 32'h3000_0000;
  localparam logic [NP-1:0]   WR   = 3'b101;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [NP-1:0]     stb   = '0;
  logic [NP-1:0]     cyc   = '0;
  logic [NP-1:0]     we    = '0;
  logic [4*NP-1:0]   sel   = '0;
  logic [32*NP-1:0]  dat   = '0;
  logic [32*NP-1:0]  adr   = '0;
  logic [NP-1:0]     ack;
  logic [32*NP-1:0]  dat_o;
  logic              ram_clk, csb, web;
  logic [3:0]        wmask;
  logic [AW-1:0]     raddr;
  logic [31:0]       din, dout;

  logic [31:0] ram_mem [256] = '{default: 32'h0};
  logic [31:0] rd_pipe [RL];
  logic [31:0] exp_mem [256];
  int checks = 0;
  int errors = 0;

  wb_openram_arbiter #(
    .NUM_PORTS(NP), .BASE_ADDR(BASE), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL), .WRITABLE(WR)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_dat_i(dat), .wbs_adr_i(adr), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
    .ram_clk0(ram_clk), .ram_csb0(csb), .ram_web0(web), .ram_wmask0(wmask),
    .ram_addr0(raddr), .ram_din0(din), .ram_dout0(dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!csb && !web)
      for (int b = 0; b < 4; b++)
        if (wmask[b]) ram_mem[raddr][8*b +: 8] <= din[8*b +: 8];
    rd_pipe[0] <= (!csb && web) ? ram_mem[raddr] : 32'hx;
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign dout = rd_pipe[RL-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete master transaction; the FSM must be idle when called.
  task automatic access(input int p, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
    bit          inwin, ro, got;
    int          widx, lat, exp_lat;
    logic [31:0] prev;
    inwin   = (a >= BASE) && (a < BASE + 32'(4 << AW));
    widx    = int'((a - BASE) >> 2);
    ro      = w && !WR[p];
    exp_lat = ro ? 1 : (w ? 2 : 2 + RL);
    prev    = dat_o[32*p +: 32];
    stb[p] = 1'b1; cyc[p] = 1'b1; we[p] = w;
    adr[32*p +: 32] = a; dat[32*p +: 32] = d; sel[4*p +: 4] = s;
    lat = 0; got = 1'b0;
    while (lat < 12 && !got) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && inwin && !ro) begin
        check("issue_csb", 32'(csb), 32'h0);
        check("issue_web", 32'(web), 32'(!w));
        check("issue_addr", 32'(raddr), 32'(widx));
        if (w) begin
          check("issue_wmask", 32'(wmask), 32'(s));
          check("issue_din", din, d);
        end
      end
      if (ro || !inwin) check("idle_csb", 32'(csb), 32'h1);
      if (ack != '0) got = 1'b1;
    end
    if (inwin) begin
      check("ack_latency", lat, exp_lat);
      check("ack_port", 32'(ack), 32'(1 << p));
      if (!w) begin
        check("read_data", dat_o[32*p +: 32], exp_mem[widx]);
      end else begin
        check("write_keeps_dat", dat_o[32*p +: 32], prev);
        if (!ro)
          for (int b = 0; b < 4; b++)
            if (s[b]) exp_mem[widx][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      check("oow_no_ack", 32'(got), 32'h0);
    end
    stb[p] = 1'b0; cyc[p] = 1'b0; we[p] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          p, last, nacks, prev_c, wnr;
    bit          w;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) exp_mem[i] = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_csb", 32'(csb), 32'h1);
    check("rst_web", 32'(web), 32'h1);
    check("rst_wmask", 32'(wmask), 32'h0);
    check("rst_addr", 32'(raddr), 32'h0);
    check("rst_din", din, 32'h0);
    check("rst_ack", 32'(ack), 32'h0);
    check("rst_dat", dat_o[31:0], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    access(0, 1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
    access(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    access(0, 1'b1, 32'h3000_0010, 32'h0000_AB00, 4'b0010);
    access(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    check("bytemask_value", exp_mem[4], 32'hDEAD_ABEF);
    access(1, 1'b1, 32'h3000_0010, 32'h1234_5678, 4'hF);
    access(0, 1'b0, 32'h3000_0010, 32'h0, 4'hF);
    access(2, 1'b0, 32'h3000_0400, 32'h0, 4'hF);
    access(2, 1'b1, 32'h3000_03FC, 32'hCAFE_F00D, 4'hF);
    access(1, 1'b0, 32'h3000_03FF, 32'h0, 4'hF);

    // Granted master abandons a read after the RAM has been issued.
    stb[0] = 1'b1; cyc[0] = 1'b1; we[0] = 1'b0; adr[31:0] = 32'h3000_0010;
    @(negedge clk);
    stb[0] = 1'b0; cyc[0] = 1'b0;
    for (int c = 2; c <= 2 + RL; c++) begin
      @(negedge clk);
      check("drop_no_ack", 32'(ack), 32'h0);
    end
    @(negedge clk);
    access(1, 1'b0, 32'h3000_0010, 32'h0, 4'hF);

    for (int n = 0; n < 40; n++) begin
      p = int'($urandom_range(0, NP - 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)       a = BASE + 32'h400 + 32'($urandom_range(0, 255));
      else if ($urandom_range(0, 9) == 0)  a = BASE + 32'h3FC + 32'($urandom_range(0, 3));
      else                                 a = BASE + 32'($urandom_range(0, 31));
      access(p, w, a, $urandom, 4'($urandom_range(0, 15)));
    end

    // Reset lands while a read is waiting on the RAM.
    stb[0] = 1'b1; cyc[0] = 1'b1; we[0] = 1'b0; adr[31:0] = 32'h3000_0020;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; stb[0] = 1'b0; cyc[0] = 1'b0;
    @(negedge clk);
    check("midrst_csb", 32'(csb), 32'h1);
    check("midrst_ack", 32'(ack), 32'h0);
    check("midrst_dat", dat_o[31:0], 32'h0);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("postrst_no_ack", 32'(ack), 32'h0);
    end

    for (int q = 0; q < NP; q++) begin
      stb[q] = 1'b1; cyc[q] = 1'b1; we[q] = 1'b0;
      adr[32*q +: 32] = BASE + 32'(16 * (q + 1));
    end
    last = NP - 1; nacks = 0; prev_c = -1;
    for (int c = 0; c < 80 && nacks < 6; c++) begin
      @(negedge clk);
      if (ack != '0) begin
        wnr  = (last + 1) % NP;
        last = wnr;
        check("cont_port", 32'(ack), 32'(1 << wnr));
        check("cont_data", dat_o[32*wnr +: 32], exp_mem[4 * (wnr + 1)]);
        if (nacks > 0) check("cont_gap", c - prev_c, 3 + RL);
        prev_c = c;
        nacks++;
      end
    end
    check("cont_count", nacks, 6);
    stb = '0; cyc = '0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_openram_arbiter.md
Name: wb_openram_arbiter

Overview:
Parametrised N-port Wishbone slave that shares the single RW port of one OpenRAM macro among NUM_PORTS masters, on one clock domain. It provides round-robin arbitration, byte-masked writes, configurable RAM read latency, per-port write permission and address-window decode. It sits between the caravel/user Wishbone fabric and an OpenRAM instance, replacing fixed two-port RW/R steering where more masters or a single-port macro are used.

Parameters:
NUM_PORTS, 2, number of Wishbone slave ports (1..8)
BASE_ADDR, 32'h3000_0000, byte base address of the RAM window
ADDR_WIDTH, 8, RAM word-address width; window size = 4*2^ADDR_WIDTH bytes
READ_LATENCY, 1, clock edges from the RAM sampling a read to ram_dout0 being valid (1..3)
WRITABLE, {NUM_PORTS{1'b1}}, per-port bitmap; bit i = 0 makes port i read-only

Ports:
wb_clk_i  in  1  single clock for all logic; forwarded to the RAM
wb_rst_n_i  in  1  synchronous, active-low reset
wbs_stb_i  in  NUM_PORTS  per-port strobe
wbs_cyc_i  in  NUM_PORTS  per-port cycle
wbs_we_i  in  NUM_PORTS  per-port write enable
wbs_sel_i  in  4*NUM_PORTS  byte selects; port i at [4i+3:4i]
wbs_dat_i  in  32*NUM_PORTS  write data; port i at [32i+31:32i]
wbs_adr_i  in  32*NUM_PORTS  byte address; port i at [32i+31:32i]
wbs_ack_o  out  NUM_PORTS  one-cycle acknowledge per port
wbs_dat_o  out  32*NUM_PORTS  read data, replicated per port, valid with ack
ram_clk0  out  1  equals wb_clk_i
ram_csb0  out  1  active-low chip select (registered)
ram_web0  out  1  active-low write enable (registered)
ram_wmask0  out  4  byte write mask (registered)
ram_addr0  out  ADDR_WIDTH  word address (registered)
ram_din0  out  32  write data (registered)
ram_dout0  in  32  RAM read data

Behaviour:
- Reset is sampled on the rising edge of wb_clk_i while wb_rst_n_i=0. All outputs are reset values: ram_csb0=1, ram_web0=1, ram_wmask0=0, ram_addr0=0, ram_din0=0, wbs_ack_o=0, wbs_dat_o=0. FSM goes to IDLE; rr_ptr=NUM_PORTS-1, so port 0 has top priority first.
- Port i requests when stb&cyc=1 and adr[31:ADDR_WIDTH+2]==BASE_ADDR[31:ADDR_WIDTH+2]. Out-of-window requests are never acked.
- Word address = adr[ADDR_WIDTH+1:2]; adr[1:0] is ignored.
- Arbitration happens only in IDLE. The winner is the first requesting port scanning rr_ptr+1, rr_ptr+2, … with wrap modulo NUM_PORTS. rr_ptr is updated to the winner on grant.
- FSM states: IDLE, ISSUE, WAIT, ACK.
- IDLE with a winner, cycle 0: register addr, din=dat_i, wmask=sel_i, web=~we_i; set csb=0; go to ISSUE.
- Read-only port write: csb stays 1, web=1, go directly to ACK. The write is silently dropped but acked.
- IDLE with no winner: stay in IDLE.
- ISSUE, cycle 1: the RAM samples at the end of this cycle. The next edge sets csb=1, web=1, wmask=0.
  - Write: go to ACK.
  - Read: go to WAIT with counter=READ_LATENCY-1.
- WAIT: decrement the counter. When it is 0, capture ram_dout0 into the data register and go to ACK.
- ACK: assert wbs_ack_o[grant] for exactly one cycle; wbs_dat_o holds the captured data. Next state is IDLE. The granted port's still-high stb is not re-arbitrated in this cycle.
- Latency from the request-sampled cycle 0: write ack in cycle 2; read ack in cycle 2+READ_LATENCY; read-only-write ack in cycle 1.
- Throughput: one access per 3 cycles for writes, 3+READ_LATENCY for reads.
- Granted master drops cyc before ack: the RAM access completes (a committed write is not undone). The ack is suppressed, and the FSM returns to IDLE on schedule.
- Requests from non-granted ports are held off (no ack) until they win.
- wbs_dat_o keeps its last captured value between reads; write acks leave it unchanged.
- Reset mid-operation: the next edge forces the reset state and aborts any pending ack. A RAM write already sampled is not reverted.

Test Plan:
- Reset then single write on port 0: adr=0x3000_0010, dat=0xDEADBEEF, sel=4'hF → ram_addr0=4, ram_csb0=0 and ram_web0=0 in cycle 1, ack[0] in cycle 2. A subsequent read from 0x3000_0010 with READ_LATENCY=1 → ack in cycle 3 with dat_o=0xDEADBEEF.
- Byte mask: write sel=4'b0010 dat=0x0000AB00 over 0xDEADBEEF → ram_wmask0=4'b0010; readback 0xDEADABEF (RAM model).
- Contention, NUM_PORTS=3: all three ports request reads continuously → grant order 0,1,2,0, with one ack per transaction and no port starved.
- Read-only port: WRITABLE=3'b101, port 1 writes → ack[1] in cycle 1, ram_csb0 stays 1, memory unchanged.
- Out of window: adr=0x3000_0400 with ADDR_WIDTH=8 → no ack, csb stays 1, FSM stays in IDLE. Master drops cyc mid-read → no ack, FSM back in IDLE after 2+READ_LATENCY cycles.
- Reset asserted (wb_rst_n_i=0) during WAIT with READ_LATENCY=3 → next edge has csb=1 and ack=0. After release, port 0 wins first.
